multicycle_sequencer: RTL and testbench
=======================================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have parameter OP, default 4: opcode width.
REQ-002 SHALL have parameter ALU_OP, default 4: ALU operation code width.
REQ-003 SHALL have parameter CNT_W, default 16: retired-instruction counter width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 op_in  in  OP  opcode field of the word returned by memory, valid when mem_ready=1 in FETCH.
REQ-007 zero  in  1  datapath zero flag, sampled in EXEC.
REQ-008 mem_ready  in  1  memory completion, single-cycle pulse per access.
REQ-009 mem_req  out  1  memory access request.
REQ-010 mem_we  out  1  memory write (valid with mem_req).
REQ-011 ir_we  out  1  instruction register load.
REQ-012 pc_we  out  1  PC update.
REQ-013 pc_src  out  2  PC source: 0=PC+1, 1=branch target, 2=jump target.
REQ-014 reg_we  out  1  register-file write.
REQ-015 wb_sel  out  1  write-back source: 0=ALU, 1=memory.
REQ-016 sp_inc / sp_dec  out  1 each  stack-pointer adjust.
REQ-017 alu_op  out  ALU_OP  ALU operation.
REQ-018 state  out  3  current state encoding (debug).
REQ-019 retired  out  CNT_W  count of completed instructions.

Function
REQ-020 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5-7 SHALL go to FETCH next cycle.
REQ-021 Opcodes SHALL be BRZR=0, JI=1, LD=2, ST=3, ADDI=4, PUSH=5, POP=6, MOV=7, NOT=8, AND=9, OR=10, XOR=11, ADD=12, SUB=13, SLR=14, SRR=15.
REQ-022 FETCH: mem_req=1, mem_we=0; hold until mem_ready; on mem_ready, ir_we=1, pc_we=1, pc_src=0, op_q<=op_in, next DECODE.
REQ-023 DECODE: no control outputs asserted; next EXEC unconditionally (1 cycle).
REQ-024 EXEC, BRZR: if zero=1 then pc_we=1, pc_src=1; else nothing; next FETCH; retire.
REQ-025 EXEC, JI: pc_we=1, pc_src=2; next FETCH; retire.
REQ-026 EXEC, MOV/NOT/AND/OR/XOR/ADD/SUB/SLR/SRR/ADDI: alu_op=op_q (ADDI: alu_op=12), reg_we=1, wb_sel=0; next FETCH; retire.
REQ-027 EXEC, LD/ST: alu_op=12 (address calc); next MEM.
REQ-028 EXEC, PUSH: sp_dec=1; next MEM. EXEC, POP: no strobe; next MEM.
REQ-029 MEM: mem_req=1; mem_we=1 for ST/PUSH only; hold until mem_ready.
REQ-030 MEM on mem_ready: ST/PUSH next FETCH and retire; LD next WB; POP sp_inc=1, next WB.
REQ-031 WB: reg_we=1, wb_sel=1; next FETCH; retire.
REQ-032 Latency with zero-wait memory (mem_ready in first request cycle): ALU/branch 3 cycles, ST/PUSH 4, LD/POP 5.
REQ-033 retired SHALL increment by 1 in the cycle an instruction retires and wrap from 2^CNT_W-1 to 0.
REQ-034 All strobes (ir_we, pc_we, reg_we, sp_inc, sp_dec) SHALL be single-cycle; default 0; alu_op default 0.
REQ-035 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-036 Outputs SHALL be combinational from state, op_q, zero, mem_ready only.

Reset
REQ-037 rst=1 at a clock edge SHALL set state=FETCH, op_q=0, retired=0, regardless of current state, including mid-MEM wait.
REQ-038 While rst=1 all outputs except state SHALL be 0; first cycle after release, mem_req=1 in FETCH.
REQ-039 An access abandoned by reset SHALL NOT retire nor generate reg_we/sp strobes.

Verification
REQ-040 Reset then op_in=12 (ADD), mem_ready immediate -> states 0,1,2,0; reg_we=1, alu_op=12 in EXEC; retired=1.
REQ-041 BRZR with zero=1 then zero=0 -> pc_we=1/pc_src=1 only in first; retired=2.
REQ-042 POP, mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, sp_inc at ready, WB with wb_sel=1; latency 8 cycles.
REQ-043 PUSH -> sp_dec in EXEC, mem_we=1 in MEM, no reg_we; ST likewise without sp_dec.
REQ-044 rst asserted during MEM wait of LD -> state=FETCH next cycle, no reg_we, retired unchanged.
REQ-045 Preload retired to 2^CNT_W-1 via 65535 ALU instructions (CNT_W=16), one more -> retired=0.

Source files
------------

// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multicycle sequencer and its datapath/memory.
//
// Memory handshake: the sequencer holds mem_req=1 (with mem_we qualifying
// read/write) for as long as it waits on an access; memory answers with a
// single-cycle mem_ready pulse, and the access completes in the cycle
// mem_req=1 and mem_ready=1 coincide. mem_ready seen while mem_req=0 is
// meaningless and ignored. The sequencer never withdraws a request before
// mem_ready, except when it is reset.
interface multicycle_sequencer_if #(
  parameter int OP     = 4,
  parameter int ALU_OP = 4,
  parameter int CNT_W  = 16
);
  logic [OP-1:0]     op_in;
  logic              zero;
  logic              mem_ready;
  logic              mem_req;
  logic              mem_we;
  logic              ir_we;
  logic              pc_we;
  logic [1:0]        pc_src;
  logic              reg_we;
  logic              wb_sel;
  logic              sp_inc;
  logic              sp_dec;
  logic [ALU_OP-1:0] alu_op;
  logic [2:0]        state;
  logic [CNT_W-1:0]  retired;

  modport master (
    input  op_in, zero, mem_ready,
    output mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, wb_sel,
           sp_inc, sp_dec, alu_op, state, retired
  );

  modport slave (
    output op_in, zero, mem_ready,
    input  mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, wb_sel,
           sp_inc, sp_dec, alu_op, state, retired
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH -> DECODE -> EXEC [-> MEM [-> WB]].
// Control outputs are decoded combinationally from the current state, the
// latched opcode, zero and mem_ready; retired counts completed instructions.
module multicycle_sequencer #(
  parameter int OP     = 4,
  parameter int ALU_OP = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [OP-1:0] OP_BRZR = OP'(0);
  localparam logic [OP-1:0] OP_JI   = OP'(1);
  localparam logic [OP-1:0] OP_LD   = OP'(2);
  localparam logic [OP-1:0] OP_ST   = OP'(3);
  localparam logic [OP-1:0] OP_ADDI = OP'(4);
  localparam logic [OP-1:0] OP_PUSH = OP'(5);
  localparam logic [OP-1:0] OP_POP  = OP'(6);

  localparam logic [ALU_OP-1:0] ALU_ADD = ALU_OP'(12);

  state_t           state_q;
  logic [OP-1:0]    op_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  // Opcode classes used by both the sequencing and the output decode.
  logic is_store;
  logic is_mem_op;
  assign is_store  = (op_q == OP_ST) || (op_q == OP_PUSH);
  assign is_mem_op = (op_q == OP_LD) || (op_q == OP_ST) ||
                     (op_q == OP_PUSH) || (op_q == OP_POP);

  // State sequencing, opcode capture and retired-instruction counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      if (retire) retired_q <= retired_q + CNT_W'(1);
      case (state_q)
        FETCH: begin
          if (bus.mem_ready) begin
            op_q    <= bus.op_in;
            state_q <= DECODE;
          end
        end
        DECODE: state_q <= EXEC;
        EXEC:   state_q <= is_mem_op ? MEM : FETCH;
        MEM: begin
          if (bus.mem_ready) state_q <= is_store ? FETCH : WB;
        end
        WB:      state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Control decode; everything is held at zero while reset is asserted so an
  // abandoned access cannot strobe the datapath or retire.
  always_comb begin
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    bus.ir_we   = 1'b0;
    bus.pc_we   = 1'b0;
    bus.pc_src  = 2'd0;
    bus.reg_we  = 1'b0;
    bus.wb_sel  = 1'b0;
    bus.sp_inc  = 1'b0;
    bus.sp_dec  = 1'b0;
    bus.alu_op  = '0;
    retire      = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          bus.mem_req = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_we = 1'b1;
            bus.pc_we = 1'b1;
          end
        end
        EXEC: begin
          if (op_q == OP_BRZR) begin
            if (bus.zero) begin
              bus.pc_we  = 1'b1;
              bus.pc_src = 2'd1;
            end
            retire = 1'b1;
          end else if (op_q == OP_JI) begin
            bus.pc_we  = 1'b1;
            bus.pc_src = 2'd2;
            retire     = 1'b1;
          end else if ((op_q == OP_LD) || (op_q == OP_ST)) begin
            bus.alu_op = ALU_ADD;
          end else if (op_q == OP_PUSH) begin
            bus.sp_dec = 1'b1;
          end else if (op_q == OP_POP) begin
            bus.sp_dec = 1'b0;
          end else begin
            bus.alu_op = (op_q == OP_ADDI) ? ALU_ADD : ALU_OP'(op_q);
            bus.reg_we = 1'b1;
            retire     = 1'b1;
          end
        end
        MEM: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = is_store;
          if (bus.mem_ready) begin
            bus.sp_inc = (op_q == OP_POP);
            retire     = is_store;
          end
        end
        WB: begin
          bus.reg_we = 1'b1;
          bus.wb_sel = 1'b1;
          retire     = 1'b1;
        end
        default: retire = 1'b0;
      endcase
    end
  end

  // Debug state is always visible; the counter reads zero during reset.
  assign bus.state   = state_q;
  assign bus.retired = rst ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: a reference model expands each instruction
// into a per-cycle trace of stimulus and expected controls, which is then
// replayed against the DUT.
module tb_multicycle_sequencer;

  // Narrow retired counter so its wrap is reachable in a short run.
  localparam int CW = 8;
  localparam int W  = 24;

  logic clk;
  logic rst;

  multicycle_sequencer_if #(.OP(4), .ALU_OP(4), .CNT_W(CW)) bus ();

  multicycle_sequencer #(.OP(4), .ALU_OP(4), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard ----------------
  // entry layout: [23] retire, [22] mem_ready, [21] zero, [20:17] op_in,
  //               [16:14] state, [13:0] control vector
  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] exp_ret;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // control vector order: mem_req mem_we ir_we pc_we pc_src reg_we wb_sel sp_inc sp_dec alu_op
  function automatic logic [13:0] v(input logic mreq, input logic mwe, input logic irwe,
                                    input logic pcwe, input logic [1:0] pcs, input logic rwe,
                                    input logic wbs, input logic spi, input logic spd,
                                    input logic [3:0] alu);
    return {mreq, mwe, irwe, pcwe, pcs, rwe, wbs, spi, spd, alu};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {bus.mem_req, bus.mem_we, bus.ir_we, bus.pc_we, bus.pc_src, bus.reg_we,
            bus.wb_sel, bus.sp_inc, bus.sp_dec, bus.alu_op};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom);
  endfunction

  function automatic void push(input logic [2:0] st, input logic mr, input logic z,
                               input logic [3:0] op, input logic [13:0] vec, input logic ret);
    exp_q.push_back({ret, mr, z, op, st, vec});
  endfunction

  // Reference model: one instruction as seen on the control outputs.
  // fw/mw = idle cycles before mem_ready in FETCH/MEM; abort stops the trace
  // inside the MEM wait (the caller then applies reset).
  function automatic void gen(input int op, input logic z, input int fw, input int mw,
                              input logic abort);
    logic [3:0]  o;
    logic        store;
    logic        memop;
    logic        load;
    logic [13:0] ev;
    logic        last;
    o     = 4'(op);
    store = (op == 3) || (op == 5);
    load  = (op == 2) || (op == 6);
    memop = store || load;
    for (int k = 0; k <= fw; k++) begin
      last = (k == fw);
      push(3'd0, last, rb(), o, v(1'b1, 1'b0, last, last, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0), 1'b0);
    end
    push(3'd1, rb(), rb(), rop(), 14'd0, 1'b0);
    case (op)
      0:       ev = z ? v(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0) : 14'd0;
      1:       ev = v(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      2, 3:    ev = v(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd12);
      5:       ev = v(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      6:       ev = 14'd0;
      default: ev = v(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0,
                      (op == 4) ? 4'd12 : o);
    endcase
    push(3'd2, rb(), z, rop(), ev, !memop);
    if (memop) begin
      for (int j = 0; j <= mw; j++) begin
        last = (j == mw);
        if (abort && last) break;
        push(3'd3, last, rb(), rop(),
             v(1'b1, store, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, (op == 6) && last, 1'b0, 4'd0),
             store && last);
      end
      if (load && !abort)
        push(3'd4, rb(), rb(), rop(), v(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0), 1'b1);
    end
  endfunction

  // ---------------- driver ----------------
  // Replays the queued trace; called at a falling edge, returns at one.
  task automatic play();
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.mem_ready = e[22];
      bus.zero      = e[21];
      bus.op_in     = e[20:17];
      #1;
      chk("state", 32'(bus.state), 32'(e[16:14]));
      chk("ctrl", 32'(dut_vec()), 32'(e[13:0]));
      chk("retired", 32'(bus.retired), 32'(exp_ret));
      if (e[23]) exp_ret++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      bus.mem_ready = rb();
      bus.zero      = rb();
      bus.op_in     = rop();
      #1;
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_ctrl", 32'(dut_vec()), 32'd0);
      chk("rst_retired", 32'(bus.retired), 32'd0);
    end
    @(negedge clk);
    rst     = 1'b0;
    exp_ret = '0;
  endtask

  function automatic int rand_op();
    return int'($urandom_range(0, 15));
  endfunction

  function automatic int rand_alu_op();
    int k;
    k = int'($urandom_range(7, 16));
    return (k == 16) ? 4 : k;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    bus.op_in     = 4'd0;
    exp_ret       = '0;

    do_reset(2);

    // LD abandoned by reset during its MEM wait
    gen(2, 1'b0, 0, 2, 1'b1);
    play();
    rst           = 1'b1;
    bus.mem_ready = rb();
    #1;
    chk("abort_state", 32'(bus.state), 32'd3);
    chk("abort_ctrl", 32'(dut_vec()), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst           = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    chk("abort_next_state", 32'(bus.state), 32'd0);
    chk("abort_next_ctrl", 32'(dut_vec()), 32'(v(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0)));
    chk("abort_retired", 32'(bus.retired), 32'd0);
    exp_ret = '0;

    // ADD with zero-wait memory
    gen(12, 1'b0, 0, 0, 1'b0);
    play();
    chk("add_retired", 32'(bus.retired), 32'd1);

    // BRZR taken then not taken
    do_reset(1);
    gen(0, 1'b1, 0, 0, 1'b0);
    gen(0, 1'b0, 0, 0, 1'b0);
    play();
    chk("brzr_retired", 32'(bus.retired), 32'd2);

    // POP with mem_ready delayed three cycles, then PUSH, ST, LD, JI
    gen(6, rb(), 0, 3, 1'b0);
    gen(5, rb(), 0, 0, 1'b0);
    gen(3, rb(), 1, 2, 1'b0);
    gen(2, rb(), 2, 1, 1'b0);
    gen(1, rb(), 0, 0, 1'b0);
    play();

    // random instruction mix with random memory waits
    for (int i = 0; i < 150; i++) begin
      gen(rand_op(), rb(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
      play();
    end

    // run the counter up to all-ones, then one more to wrap it
    for (int i = 0; i < 600 && exp_ret != {CW{1'b1}}; i++) begin
      gen(rand_alu_op(), rb(), 0, 0, 1'b0);
      play();
    end
    chk("pre_wrap", 32'(bus.retired), 32'((1 << CW) - 1));
    gen(12, 1'b0, 0, 0, 1'b0);
    play();
    chk("wrap", 32'(bus.retired), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
